// File: rtl/sm_regdump.sv
// Register-dump UART transmitter: on start, sends 0xA5 then each debug register MSB byte first, 8N1.
// Frame starts the cycle after start is accepted; start is ignored while busy or while done pulses.
module sm_regdump #(
   parameter int CLK_DIV   = 434,
   parameter int REG_FIRST = 0,
   parameter int REG_LAST  = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [4:0]  regAddr,
   input  logic [31:0] regData,
   output logic        uartTx,
   output logic        busy,
   output logic        done
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_HDR  = 2'd1;
   localparam logic [1:0] W_DATA = 2'd2;

   localparam logic [3:0] B_START = 4'd0;
   localparam logic [3:0] B_BIT7  = 4'd8;
   localparam logic [3:0] B_STOP  = 4'd9;

   localparam logic [4:0] ADDR_FIRST = 5'(REG_FIRST);
   localparam logic [4:0] ADDR_LAST  = 5'(REG_LAST);
   localparam logic [7:0] HDR_BYTE   = 8'hA5;

   logic [1:0]       wordState;
   logic [3:0]       bitState;
   logic [DIV_W-1:0] divCnt;
   logic [1:0]       byteIdx;
   logic [7:0]       txShift;
   // Byte 0 goes out straight from regData at capture, so only the low three bytes are held.
   logic [23:0]      shadow;
   logic             lastWord;
   logic             bitEnd;

   assign bitEnd = (wordState != W_IDLE) && (divCnt == DIV_MAX);
   assign busy   = (wordState != W_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wordState <= W_IDLE;
         bitState  <= B_START;
         divCnt    <= '0;
         byteIdx   <= 2'd0;
         txShift   <= 8'd0;
         shadow    <= 24'd0;
         lastWord  <= 1'b0;
         regAddr   <= 5'd0;
         uartTx    <= 1'b1;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wordState == W_IDLE) begin
            if (start && !done) begin
               wordState <= W_HDR;
               bitState  <= B_START;
               divCnt    <= '0;
               byteIdx   <= 2'd0;
               lastWord  <= 1'b0;
               regAddr   <= ADDR_FIRST;
               txShift   <= HDR_BYTE;
               uartTx    <= 1'b0;
            end
         end else if (!bitEnd) begin
            divCnt <= divCnt + 1'b1;
         end else begin
            divCnt <= '0;
            if (bitState != B_STOP) begin
               bitState <= bitState + 4'd1;
               if (bitState == B_BIT7) begin
                  uartTx <= 1'b1;
               end else begin
                  uartTx  <= txShift[0];
                  txShift <= txShift >> 1;
               end
            end else if (wordState == W_HDR || byteIdx == 2'd3) begin
               if (wordState == W_DATA && lastWord) begin
                  wordState <= W_IDLE;
                  bitState  <= B_START;
                  byteIdx   <= 2'd0;
                  lastWord  <= 1'b0;
                  regAddr   <= 5'd0;
                  uartTx    <= 1'b1;
                  done      <= 1'b1;
               end else begin
                  wordState <= W_DATA;
                  bitState  <= B_START;
                  byteIdx   <= 2'd0;
                  shadow    <= regData[23:0];
                  txShift   <= regData[31:24];
                  uartTx    <= 1'b0;
               end
            end else begin
               byteIdx  <= byteIdx + 2'd1;
               bitState <= B_START;
               uartTx   <= 1'b0;
               case (byteIdx)
                  2'd0:    txShift <= shadow[23:16];
                  2'd1:    txShift <= shadow[15:8];
                  default: txShift <= shadow[7:0];
               endcase
               // Moving the address a full byte early gives the next capture 10 bit times of settling.
               if (byteIdx == 2'd2) begin
                  if (regAddr == ADDR_LAST) lastWord <= 1'b1;
                  else                      regAddr  <= regAddr + 5'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sm_regdump.sv
// Bench for sm_regdump: two instances (short frame at CLK_DIV=4, full range at CLK_DIV=2) against a byte/timing model.
module tb_sm_regdump;
   localparam int DA = 4, FA = 2, LA = 2;
   localparam int DB = 2, FB = 0, LB = 31;

   logic        clk = 1'b0, rst_n = 1'b0, startA = 1'b0, startB = 1'b0;
   logic [4:0]  regAddrA, regAddrB;
   logic [31:0] regDataA, regDataB;
   logic        uartTxA, uartTxB, busyA, busyB, doneA, doneB;
   logic [31:0] mem [32];

   int cyc = 0, checks = 0, errors = 0, E = 0;
   int badA = 0, badB = 0;
   logic [7:0] rxQA[$], rxQB[$], expQ[$];
   int rxTA[$], rxTB[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign regDataB = mem[regAddrB];

   sm_regdump #(.CLK_DIV(DA), .REG_FIRST(FA), .REG_LAST(LA)) dutA (
      .clk(clk), .rst_n(rst_n), .start(startA), .regAddr(regAddrA), .regData(regDataA),
      .uartTx(uartTxA), .busy(busyA), .done(doneA));

   sm_regdump #(.CLK_DIV(DB), .REG_FIRST(FB), .REG_LAST(LB)) dutB (
      .clk(clk), .rst_n(rst_n), .start(startB), .regAddr(regAddrB), .regData(regDataB),
      .uartTx(uartTxB), .busy(busyB), .done(doneB));

   function automatic logic txOf(int sel);   return (sel == 0) ? uartTxA : uartTxB; endfunction
   function automatic logic busyOf(int sel); return (sel == 0) ? busyA : busyB; endfunction
   function automatic logic doneOf(int sel); return (sel == 0) ? doneA : doneB; endfunction
   function automatic logic [4:0] addrOf(int sel); return (sel == 0) ? regAddrA : regAddrB; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Receives one byte whose start bit is visible now; every cycle of every bit must hold its level.
   task automatic rxByte(input int sel, input int div, output logic [7:0] b, output int bad, output bit ab);
      logic v;
      bad = 0; ab = 1'b0; b = 8'd0;
      for (int bi = 0; bi < 10; bi++) begin
         for (int c = 0; c < div; c++) begin
            if (!(bi == 0 && c == 0)) @(negedge clk);
            if (!rst_n) begin ab = 1'b1; return; end
            v = txOf(sel);
            if (bi == 0 && v !== 1'b0) bad++;
            if (bi == 9 && v !== 1'b1) bad++;
            if (bi >= 1 && bi <= 8) begin
               if (c == 0) b[bi-1] = v;
               else if (v !== b[bi-1]) bad++;
            end
         end
      end
   endtask

   always begin : decA
      logic [7:0] b; int nb; bit ab; int st;
      @(negedge clk);
      if (rst_n && uartTxA === 1'b0) begin
         st = cyc;
         rxByte(0, DA, b, nb, ab);
         if (!ab) begin badA += nb; rxQA.push_back(b); rxTA.push_back(st); end
      end
   end

   always begin : decB
      logic [7:0] b; int nb; bit ab; int st;
      @(negedge clk);
      if (rst_n && uartTxB === 1'b0) begin
         st = cyc;
         rxByte(1, DB, b, nb, ab);
         if (!ab) begin badB += nb; rxQB.push_back(b); rxTB.push_back(st); end
      end
   end

   // Expected regAddr in cycle t (t=1 is the first cycle after the accepting edge); -1 = not checked.
   function automatic int expAddr(int t, int D, int first, int last, int T);
      int q, i, b;
      if (t < 1) return -1;
      if (t > T) return 0;
      q = (t - 1) / (10 * D);
      if (q == 0) return first;
      i = (q - 1) / 4;
      b = (q - 1) % 4;
      if (b == 3) return (first + i == last) ? -1 : first + i + 1;
      return first + i;
   endfunction

   task automatic buildExp(input int sel, input int first, input int last);
      logic [31:0] w;
      expQ.delete();
      expQ.push_back(8'hA5);
      for (int k = first; k <= last; k++) begin
         w = (sel == 0) ? regDataA : mem[k];
         expQ.push_back(w[31:24]); expQ.push_back(w[23:16]);
         expQ.push_back(w[15:8]);  expQ.push_back(w[7:0]);
      end
   endtask

   task automatic kick(input int sel, input bit hold);
      @(posedge clk); #1;
      if (sel == 0) begin rxQA.delete(); rxTA.delete(); badA = 0; startA = 1'b1; end
      else          begin rxQB.delete(); rxTB.delete(); badB = 0; startB = 1'b1; end
      @(posedge clk); #1;
      E = cyc;
      if (!hold) begin startA = 1'b0; startB = 1'b0; end
   endtask

   task automatic runFrame(input int sel, input int D, input int first, input int last,
                           input bit hold, input int tearAddr, input int breakAt);
      int n, T, t, ea, busyCnt, doneT, dones, addrErr;
      n = last - first + 1;
      T = (1 + 4 * n) * 10 * D;
      busyCnt = 0; doneT = -1; dones = 0; addrErr = 0;
      for (int w = 0; w < T + 8; w++) begin
         @(negedge clk);
         t = cyc - E + 1;
         if (breakAt > 0 && t == breakAt) return;
         if (busyOf(sel)) busyCnt++;
         if (doneOf(sel)) begin dones++; if (doneT < 0) doneT = t; end
         if (t == 1) chk("tx_first_cycle", {31'd0, txOf(sel)}, 32'd0);
         if (t == T + 1) chk("tx_idle_at_done", {31'd0, txOf(sel)}, 32'd1);
         ea = expAddr(t, D, first, last, T);
         if (ea >= 0 && addrOf(sel) !== 5'(ea)) addrErr++;
         if (tearAddr >= 0 && t == 1 + 10 * D * (2 + 4 * (tearAddr - first)) + 3)
            mem[tearAddr] = mem[tearAddr] ^ ($urandom | 32'd1);
         if (hold && doneT >= 0 && t == doneT + 1) begin
            if (sel == 0) startA = 1'b0; else startB = 1'b0;
         end
      end
      startA = 1'b0; startB = 1'b0;
      chk("busy_cycles", busyCnt, T);
      chk("done_cycle", doneT, T + 1);
      chk("done_pulses", dones, 1);
      chk("regaddr_track", addrErr, 0);
   endtask

   task automatic checkBytes(input int sel, input int D);
      logic [7:0] q[$];
      int ts[$];
      int bad, terr, m;
      if (sel == 0) begin q = rxQA; ts = rxTA; bad = badA; end
      else          begin q = rxQB; ts = rxTB; bad = badB; end
      chk("byte_count", q.size(), expQ.size());
      chk("bit_framing", bad, 0);
      m = (q.size() < expQ.size()) ? q.size() : expQ.size();
      terr = 0;
      for (int i = 0; i < m; i++) begin
         chk($sformatf("byte[%0d]", i), {24'd0, q[i]}, {24'd0, expQ[i]});
         if (ts[i] - E + 1 != 1 + i * 10 * D) terr++;
      end
      chk("byte_start_timing", terr, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int idleBusy, idleDone;
      regDataA = 32'd0;
      for (int k = 0; k < 32; k++) mem[k] = 32'(k);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rstA_tx", {31'd0, uartTxA}, 32'd1);  chk("rstA_busy", {31'd0, busyA}, 32'd0);
      chk("rstA_done", {31'd0, doneA}, 32'd0);  chk("rstA_addr", {27'd0, regAddrA}, 32'd0);
      chk("rstB_tx", {31'd0, uartTxB}, 32'd1);  chk("rstB_busy", {31'd0, busyB}, 32'd0);
      chk("rstB_done", {31'd0, doneB}, 32'd0);  chk("rstB_addr", {27'd0, regAddrB}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Basic single-register frame.
      regDataA = 32'h12345678;
      buildExp(0, FA, LA);
      kick(0, 1'b0);
      runFrame(0, DA, FA, LA, 1'b0, -1, 0);
      checkBytes(0, DA);

      // Full range, data equals address.
      for (int k = 0; k < 32; k++) mem[k] = 32'(k);
      buildExp(1, FB, LB);
      kick(1, 1'b0);
      runFrame(1, DB, FB, LB, 1'b0, -1, 0);
      checkBytes(1, DB);

      // Random contents, register 3 rewritten mid-word.
      for (int k = 0; k < 32; k++) mem[k] = $urandom;
      buildExp(1, FB, LB);
      kick(1, 1'b0);
      runFrame(1, DB, FB, LB, 1'b0, 3, 0);
      checkBytes(1, DB);

      // start held through the frame and the done cycle.
      regDataA = $urandom;
      buildExp(0, FA, LA);
      kick(0, 1'b1);
      runFrame(0, DA, FA, LA, 1'b1, -1, 0);
      checkBytes(0, DA);
      idleBusy = 0;
      repeat (6) begin @(negedge clk); if (busyA) idleBusy++; end
      chk("no_requeue", idleBusy, 0);

      // Reset during byte 2.
      regDataA = $urandom;
      kick(0, 1'b0);
      runFrame(0, DA, FA, LA, 1'b0, -1, 90);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_tx", {31'd0, uartTxA}, 32'd1);
      chk("abort_busy", {31'd0, busyA}, 32'd0);
      chk("abort_addr", {27'd0, regAddrA}, 32'd0);
      chk("abort_done", {31'd0, doneA}, 32'd0);
      idleBusy = 0; idleDone = 0;
      repeat (60) begin
         @(negedge clk);
         if (busyA) idleBusy++;
         if (doneA) idleDone++;
      end
      chk("abort_quiet_busy", idleBusy, 0);
      chk("abort_quiet_done", idleDone, 0);

      // Clean frame after the abort.
      regDataA = $urandom;
      buildExp(0, FA, LA);
      kick(0, 1'b0);
      runFrame(0, DA, FA, LA, 1'b0, -1, 0);
      checkBytes(0, DA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
